// File: rtl/ic_fetch_pkg.sv
// Shared constants, state encoding and bus packing for the instruction-fetch stage.
package ic_fetch_pkg;

  localparam int unsigned StallBusW = 6;
  localparam int unsigned StallIc   = 1;
  localparam logic        NoStop    = 1'b0;

  localparam int unsigned IcToIdWd = 34;
  localparam int unsigned IcAdel   = 33;
  localparam int unsigned IcValid  = 32;

  localparam logic [31:0] ZeroWord   = 32'h0000_0000;
  localparam logic [31:0] ResetPcDef = 32'hbfc0_0000;

  typedef enum logic {StIdle, StWaitData} ic_state_e;

  function automatic logic [IcToIdWd-1:0] ic_bus_pack(input logic adel, input logic [31:0] pc);
    logic [IcToIdWd-1:0] bus;
    bus          = '0;
    bus[IcAdel]  = adel;
    bus[IcValid] = 1'b1;
    bus[31:0]    = pc;
    return bus;
  endfunction

endpackage

// File: rtl/ic_fetch_out_buf.sv
// One-entry buffer holding the word (or address-error marker) handed to decode.
module ic_fetch_out_buf
  import ic_fetch_pkg::*;
(
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                clear_i,
  input  logic                fill_i,
  input  logic                fill_adel_i,
  input  logic [31:0]         fill_pc_i,
  input  logic [31:0]         fill_inst_i,
  input  logic                consume_i,
  output logic                valid_o,
  output logic [IcToIdWd-1:0] bus_o,
  output logic [31:0]         inst_o
);

  logic        valid_q;
  logic        adel_q;
  logic [31:0] pc_q;
  logic [31:0] inst_q;

  // A fill in the same cycle as a consume replaces the contents.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      valid_q <= 1'b0;
      adel_q  <= 1'b0;
      pc_q    <= ZeroWord;
      inst_q  <= ZeroWord;
    end else if (clear_i) begin
      valid_q <= 1'b0;
    end else if (fill_i) begin
      valid_q <= 1'b1;
      adel_q  <= fill_adel_i;
      pc_q    <= fill_pc_i;
      inst_q  <= fill_inst_i;
    end else if (consume_i) begin
      valid_q <= 1'b0;
    end
  end

  assign valid_o = valid_q;
  assign bus_o   = valid_q ? ic_bus_pack(adel_q, pc_q) : '0;
  assign inst_o  = valid_q ? inst_q : ZeroWord;

endmodule

// File: rtl/ic_fetch.sv
// Instruction-fetch stage: owns the PC, issues one outstanding request at a time and
// squashes in-flight responses on branch or exception redirect.
module ic_fetch
  import ic_fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = ResetPcDef
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 flush,
  input  logic [31:0]          new_pc,
  input  logic                 br_e,
  input  logic [31:0]          br_addr,
  input  logic [StallBusW-1:0] stall,
  output logic                 stallreq,
  output logic                 inst_req,
  output logic [31:0]          inst_addr,
  input  logic                 inst_addr_ok,
  input  logic                 inst_data_ok,
  input  logic [31:0]          inst_rdata,
  output logic [IcToIdWd-1:0]  ic_to_id_bus,
  output logic [31:0]          ic_inst
);

  ic_state_e   state_q;
  logic [31:0] pc_q;
  logic [31:0] req_pc_q;
  logic        cancel_q;

  logic        redir;
  logic [31:0] tgt;
  logic        buf_valid;
  logic        consume;
  logic        room;
  logic        idle;
  logic        aligned;
  logic        data_ret;
  logic        fill_data;
  logic        fill_adel;
  logic        unused_stall;

  assign redir    = flush | br_e;
  assign tgt      = flush ? new_pc : br_addr;
  assign idle     = (state_q == StIdle);
  assign aligned  = (pc_q[1:0] == 2'b00);
  assign consume  = buf_valid & (stall[StallIc] == NoStop);
  assign room     = ~buf_valid | consume;
  assign data_ret = ~idle & inst_data_ok;

  assign fill_data = data_ret & ~cancel_q & ~redir;
  assign fill_adel = idle & room & ~redir & ~aligned;

  // Gated with rst so the request and starve flags read 0 while reset is held.
  assign inst_req  = rst & idle & room & ~redir & aligned;
  assign inst_addr = pc_q;
  assign stallreq  = rst & ~buf_valid & ~redir & ~(data_ret & ~cancel_q);

  assign unused_stall = ^{stall[StallBusW-1:StallIc+1], stall[StallIc-1:0]};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= StIdle;
      pc_q     <= RESET_PC;
      req_pc_q <= ZeroWord;
      cancel_q <= 1'b0;
    end else if (redir) begin
      pc_q <= tgt;
      if (!idle) begin
        // A response landing with the redirect is simply dropped; otherwise mark it stale.
        if (inst_data_ok) begin
          state_q  <= StIdle;
          cancel_q <= 1'b0;
        end else begin
          cancel_q <= 1'b1;
        end
      end
    end else if (idle) begin
      if (inst_req && inst_addr_ok) begin
        state_q  <= StWaitData;
        req_pc_q <= pc_q;
        pc_q     <= pc_q + 32'd4;
      end
    end else if (inst_data_ok) begin
      state_q  <= StIdle;
      cancel_q <= 1'b0;
    end
  end

  ic_fetch_out_buf u_out_buf (
    .clk_i       (clk),
    .rst_ni      (rst),
    .clear_i     (redir),
    .fill_i      (fill_data | fill_adel),
    .fill_adel_i (fill_adel),
    .fill_pc_i   (fill_adel ? pc_q : req_pc_q),
    .fill_inst_i (fill_adel ? ZeroWord : inst_rdata),
    .consume_i   (consume),
    .valid_o     (buf_valid),
    .bus_o       (ic_to_id_bus),
    .inst_o      (ic_inst)
  );

endmodule

// File: tb/tb_ic_fetch.sv
// Randomized bench for ic_fetch: a memory responder plus a program-order scoreboard of PCs.
module tb_ic_fetch;

  localparam logic [31:0] RstPc = 32'hbfc0_0000;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        flush, br_e, inst_addr_ok, inst_data_ok;
  logic [31:0] new_pc, br_addr, inst_rdata;
  logic [5:0]  stall;
  logic        stallreq, inst_req;
  logic [31:0] inst_addr, ic_inst;
  logic [33:0] ic_to_id_bus;

  always #5 clk = ~clk;

  ic_fetch #(.RESET_PC(RstPc)) dut (
    .clk          (clk),
    .rst          (rst),
    .flush        (flush),
    .new_pc       (new_pc),
    .br_e         (br_e),
    .br_addr      (br_addr),
    .stall        (stall),
    .stallreq     (stallreq),
    .inst_req     (inst_req),
    .inst_addr    (inst_addr),
    .inst_addr_ok (inst_addr_ok),
    .inst_data_ok (inst_data_ok),
    .inst_rdata   (inst_rdata),
    .ic_to_id_bus (ic_to_id_bus),
    .ic_inst      (ic_inst)
  );

  int checks = 0;
  int errors = 0;

  // Expected program-order PCs as decode should consume them.
  logic [31:0] exp_q[$];

  // Memory responder state.
  bit          pending = 0;
  bit          stale   = 0;
  logic [31:0] paddr   = '0;
  int unsigned cnt     = 0;
  bit          run_mon = 0;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], ~a[31:16]} ^ 32'h1357_9bdf;
  endfunction

  function automatic logic [31:0] rand_target();
    logic [31:0] t;
    t = RstPc + ($urandom_range(1023) << 2);
    if ($urandom_range(99) < 3) t = 32'hffff_fff8;
    if ($urandom_range(99) < 20) t[1:0] = 2'($urandom_range(3));
    return t;
  endfunction

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic drive_cycle();
    @(posedge clk);
    #1;
    flush        = ($urandom_range(99) < 4);
    br_e         = ($urandom_range(99) < 6);
    new_pc       = rand_target();
    br_addr      = rand_target();
    stall        = 6'($urandom);
    stall[1]     = ($urandom_range(99) < 30);
    inst_addr_ok = ($urandom_range(99) < 60);
    if (pending && cnt == 0) begin
      inst_data_ok = 1'b1;
      inst_rdata   = mem_word(paddr);
    end else begin
      inst_data_ok = 1'b0;
      inst_rdata   = $urandom;
    end
    if (flush || br_e) begin
      exp_q.delete();
      exp_q.push_back(flush ? new_pc : br_addr);
    end
    @(negedge clk);
    #1;
    if (inst_data_ok) pending = 0;
    else if (pending && cnt > 0) cnt--;
    if (pending && (flush || br_e)) stale = 1;
    if (inst_req && inst_addr_ok) begin
      pending = 1;
      stale   = 0;
      paddr   = inst_addr;
      cnt     = $urandom_range(2);
    end
  endtask

  task automatic zero_inputs();
    flush = 0; br_e = 0; new_pc = '0; br_addr = '0; stall = '0;
    inst_addr_ok = 0; inst_data_ok = 0; inst_rdata = '0;
  endtask

  task automatic release_reset();
    @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    check("first_req", 64'(inst_req), 64'(1));
    check("first_addr", 64'(inst_addr), 64'(RstPc));
    check("stallreq_empty", 64'(stallreq), 64'(1));
    exp_q.delete();
    exp_q.push_back(RstPc);
    pending = 0;
    stale   = 0;
    run_mon = 1;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_bus"}, 64'(ic_to_id_bus), 64'(0));
    check({tag, "_inst"}, 64'(ic_inst), 64'(0));
    check({tag, "_req"}, 64'(inst_req), 64'(0));
    check({tag, "_stallreq"}, 64'(stallreq), 64'(0));
  endtask

  initial begin : monitor
    logic [33:0] pbus;
    logic [31:0] pinst, preq_addr, pfill_pc, e;
    bit          phold, preq_wait, pfill_fresh, pfill_stale, redir, vld, ex_adel;
    int          idle_cyc;
    phold = 0; preq_wait = 0; pfill_fresh = 0; pfill_stale = 0; idle_cyc = 0;
    pbus = '0; pinst = '0; preq_addr = '0; pfill_pc = '0;
    forever begin
      @(negedge clk);
      if (!rst || !run_mon) begin
        phold = 0; preq_wait = 0; pfill_fresh = 0; pfill_stale = 0; idle_cyc = 0;
        continue;
      end
      redir = flush | br_e;
      vld   = ic_to_id_bus[32];
      if (!vld) begin
        check("bus_zero_invalid", 64'(ic_to_id_bus), 64'(0));
        check("inst_zero_invalid", 64'(ic_inst), 64'(0));
      end
      check("stallreq", 64'(stallreq), 64'(!vld && !redir && !(inst_data_ok && !stale)));
      if (redir) check("req_on_redir", 64'(inst_req), 64'(0));
      if (vld && stall[1]) check("req_when_full", 64'(inst_req), 64'(0));
      if (inst_req) check("addr_aligned", 64'(inst_addr[1:0]), 64'(0));
      if (phold) begin
        check("hold_bus", 64'(ic_to_id_bus), 64'(pbus));
        check("hold_inst", 64'(ic_inst), 64'(pinst));
      end
      if (preq_wait) begin
        check("req_held", 64'(inst_req), 64'(!redir));
        if (inst_req) check("addr_held", 64'(inst_addr), 64'(preq_addr));
      end
      if (pfill_fresh) begin
        check("fill_bus", 64'(ic_to_id_bus), 64'({2'b01, pfill_pc}));
        check("fill_inst", 64'(ic_inst), 64'(mem_word(pfill_pc)));
      end
      if (pfill_stale) check("stale_dropped", 64'(vld), 64'(0));

      if (!redir && vld && !stall[1]) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL sb_empty: got pc %0h, expected no output", ic_to_id_bus[31:0]);
        end else begin
          e       = exp_q.pop_front();
          ex_adel = (e[1:0] != 2'b00);
          check("sb_bus", 64'(ic_to_id_bus), 64'({ex_adel, 1'b1, e}));
          check("sb_inst", 64'(ic_inst), 64'(ex_adel ? 32'h0 : mem_word(e)));
          exp_q.push_back(ex_adel ? e : e + 32'd4);
        end
        idle_cyc = 0;
      end else if (redir) begin
        idle_cyc = 0;
      end else begin
        idle_cyc++;
      end
      if (idle_cyc > 60) begin
        checks++;
        errors++;
        $display("FAIL progress: got %0d cycles without output, expected at most 60", idle_cyc);
        idle_cyc = 0;
      end

      phold       = vld && stall[1] && !redir;
      pbus        = ic_to_id_bus;
      pinst       = ic_inst;
      preq_wait   = inst_req && !inst_addr_ok;
      preq_addr   = inst_addr;
      pfill_fresh = inst_data_ok && !stale && !redir;
      pfill_stale = inst_data_ok && (stale || redir);
      pfill_pc    = paddr;
    end
  end

  initial begin : stim
    int n;
    zero_inputs();
    #12;
    check_all_zero("reset");
    release_reset();
    repeat (1500) drive_cycle();

    // Reset while a request is outstanding.
    n = 0;
    while (!pending && n < 100) begin
      drive_cycle();
      n++;
    end
    if (!pending) begin
      checks++;
      errors++;
      $display("FAIL mid_rst_setup: got no outstanding request, expected one within 100 cycles");
    end
    @(posedge clk);
    #2;
    run_mon = 0;
    rst     = 1'b0;
    #1;
    check_all_zero("mid_reset");
    zero_inputs();
    pending = 0;
    release_reset();
    repeat (1500) drive_cycle();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
